// File: rtl/sumador_restador_serial_if.sv
// Handshake and result bundle for the bit-serial adder/subtractor.
// The master side requests operations; the slave side is the arithmetic unit.
interface sumador_restador_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] r;
    logic             cout;
    logic             ovf;

    modport master (
        output start, op, a, b,
        input  ready, done, r, cout, ovf
    );

    modport slave (
        input  start, op, a, b,
        output ready, done, r, cout, ovf
    );
endinterface

// File: rtl/sumador_restador_serial.sv
// Bit-serial adder/subtractor: one registered full-adder/full-subtractor cell
// reused WIDTH times, LSB first, with a start/ready handshake and a done pulse.
module sumador_restador_serial #(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    sumador_restador_serial_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             op_q, op_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic bit_a;
    logic bit_b;
    logic sum_bit;
    logic carry_next;

    // The single shared cell: carry for add, borrow for subtract.
    assign bit_a      = a_sh_q[0];
    assign bit_b      = b_sh_q[0];
    assign sum_bit    = bit_a ^ bit_b ^ c_q;
    assign carry_next = op_q ? ((~bit_a & bit_b) | (~bit_a & c_q) | (bit_b & c_q))
                             : (( bit_a & bit_b) | ( bit_a & c_q) | (bit_b & c_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            op_q     <= 1'b0;
            c_q      <= 1'b0;
            res_sh_q <= '0;
            r_q      <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            op_q     <= op_d;
            c_q      <= c_d;
            res_sh_q <= res_sh_d;
            r_q      <= r_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        op_d     = op_q;
        c_d      = c_q;
        res_sh_d = res_sh_q;
        r_d      = r_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    op_d    = bus.op;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {sum_bit, res_sh_q[WIDTH-1:1]};
                c_d      = carry_next;
                cnt_d    = cnt_q + CW'(1);
                // On the MSB, c_q is the carry into the MSB and carry_next the carry out.
                if (cnt_q == LAST) begin
                    r_d     = {sum_bit, res_sh_q[WIDTH-1:1]};
                    cout_d  = carry_next;
                    ovf_d   = c_q ^ carry_next;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.done  = done_q;
    assign bus.r     = r_q;
    assign bus.cout  = cout_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_sumador_restador_serial.sv
// Self-checking bench for sumador_restador_serial: vector table plus scoreboard,
// with hand-written sequences for latency, handshake and mid-operation reset.
module tb_sumador_restador_serial;
    localparam int WIDTH = 8;

    typedef struct {
        logic             op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] r;
        logic             cout;
        logic             ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   done_count;
    logic prev_done;
    vec_t sb[$];
    vec_t table_v[10];

    sumador_restador_serial_if #(.WIDTH(WIDTH)) bus ();

    sumador_restador_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent reference: whole-word arithmetic instead of a bit cell.
    function automatic vec_t model(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        vec_t         v;
        logic [WIDTH:0] full;
        v.op = op;
        v.a  = a;
        v.b  = b;
        if (!op) begin
            full   = {1'b0, a} + {1'b0, b};
            v.r    = full[WIDTH-1:0];
            v.cout = full[WIDTH];
            v.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (v.r[WIDTH-1] != a[WIDTH-1]);
        end else begin
            full   = {1'b0, a} - {1'b0, b};
            v.r    = full[WIDTH-1:0];
            v.cout = (a < b);
            v.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (v.r[WIDTH-1] != a[WIDTH-1]);
        end
        return v;
    endfunction

    // Waits for ready at a falling edge, requests, and returns just after the accept edge.
    task automatic applyStimulus(input vec_t v);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!bus.ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.ready) begin
            checkOutput("ready_timeout", 32'(bus.ready), 32'd1);
        end else begin
            bus.start = 1'b1;
            bus.op    = v.op;
            bus.a     = v.a;
            bus.b     = v.b;
            sb.push_back(v);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
    endtask

    task automatic drainScoreboard();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    // Scoreboard monitor: every done pulse consumes exactly one expected result.
    initial begin
        vec_t e;
        prev_done  = 1'b0;
        done_count = 0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                done_count++;
                checkOutput("done_not_consecutive", 32'(prev_done), 32'd0);
                if (sb.size() == 0) begin
                    checkOutput("done_unexpected", 32'(bus.done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput($sformatf("r op=%0d a=%0h b=%0h", e.op, e.a, e.b), 32'(bus.r), 32'(e.r));
                    checkOutput($sformatf("cout op=%0d a=%0h b=%0h", e.op, e.a, e.b), 32'(bus.cout), 32'(e.cout));
                    checkOutput($sformatf("ovf op=%0d a=%0h b=%0h", e.op, e.a, e.b), 32'(bus.ovf), 32'(e.ovf));
                    checkOutput("ready_with_done", 32'(bus.ready), 32'd1);
                end
            end
            prev_done = rst_n ? bus.done : 1'b0;
        end
    end

    initial begin
        vec_t v;
        int   base;
        table_v[0] = '{op: 1'b0, a: 8'h7F, b: 8'h01, r: 8'h80, cout: 1'b0, ovf: 1'b1};
        table_v[1] = '{op: 1'b0, a: 8'hFF, b: 8'h01, r: 8'h00, cout: 1'b1, ovf: 1'b0};
        table_v[2] = '{op: 1'b1, a: 8'h05, b: 8'h07, r: 8'hFE, cout: 1'b1, ovf: 1'b0};
        table_v[3] = '{op: 1'b1, a: 8'h80, b: 8'h01, r: 8'h7F, cout: 1'b0, ovf: 1'b1};
        table_v[4] = '{op: 1'b0, a: 8'h10, b: 8'h20, r: 8'h30, cout: 1'b0, ovf: 1'b0};
        table_v[5] = '{op: 1'b1, a: 8'h30, b: 8'h10, r: 8'h20, cout: 1'b0, ovf: 1'b0};
        table_v[6] = '{op: 1'b0, a: 8'h0F, b: 8'h01, r: 8'h10, cout: 1'b0, ovf: 1'b0};
        table_v[7] = '{op: 1'b1, a: 8'h00, b: 8'h01, r: 8'hFF, cout: 1'b1, ovf: 1'b0};
        table_v[8] = '{op: 1'b0, a: 8'h80, b: 8'h80, r: 8'h00, cout: 1'b1, ovf: 1'b1};
        table_v[9] = '{op: 1'b1, a: 8'h7F, b: 8'hFF, r: 8'h80, cout: 1'b1, ovf: 1'b1};

        checks    = 0;
        errors    = 0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        checkOutput("reset_ready", 32'(bus.ready), 32'd1);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_r", 32'(bus.r), 32'd0);
        checkOutput("reset_cout", 32'(bus.cout), 32'd0);
        checkOutput("reset_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: done exactly WIDTH edges after the accept edge, then low again.
        applyStimulus(table_v[0]);
        for (int k = 1; k <= WIDTH + 2; k++) begin
            @(negedge clk);
            checkOutput($sformatf("latency_done_cycle%0d", k), 32'(bus.done), (k == WIDTH + 1) ? 32'd1 : 32'd0);
        end
        drainScoreboard();

        for (int i = 1; i < 10; i++) begin
            if (i != 4 && i != 5) applyStimulus(table_v[i]);
        end
        drainScoreboard();

        for (int i = 0; i < 6; i++) begin
            v = model(1'(i % 2), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            applyStimulus(v);
        end
        drainScoreboard();

        // Handshake: stray starts and input churn mid-run, then a start held in the done cycle.
        base = done_count;
        applyStimulus(table_v[4]);
        for (int k = 1; k <= WIDTH; k++) begin
            @(negedge clk);
            checkOutput("ready_low_while_running", 32'(bus.ready), 32'd0);
            bus.start = 1'(k % 2);
            bus.op    = 1'($urandom_range(0, 1));
            bus.a     = (k == 3) ? 8'hAA : 8'($urandom_range(0, 255));
            bus.b     = (k == 3) ? 8'h55 : 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        checkOutput("first_done", 32'(bus.done), 32'd1);
        bus.start = 1'b1;
        bus.op    = table_v[5].op;
        bus.a     = table_v[5].a;
        bus.b     = table_v[5].b;
        sb.push_back(table_v[5]);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 1; k <= WIDTH + 1; k++) begin
            @(negedge clk);
            checkOutput($sformatf("b2b_done_cycle%0d", k), 32'(bus.done), (k == WIDTH + 1) ? 32'd1 : 32'd0);
        end
        drainScoreboard();
        checkOutput("handshake_done_count", 32'(done_count - base), 32'd2);

        // Reset three bits into an operation: immediate clear and no completion.
        base = done_count;
        applyStimulus(table_v[6]);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        sb.delete();
        checkOutput("midrst_ready", 32'(bus.ready), 32'd1);
        checkOutput("midrst_done", 32'(bus.done), 32'd0);
        checkOutput("midrst_r", 32'(bus.r), 32'd0);
        checkOutput("midrst_cout", 32'(bus.cout), 32'd0);
        checkOutput("midrst_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        checkOutput("midrst_no_done", 32'(done_count - base), 32'd0);
        applyStimulus(table_v[6]);
        drainScoreboard();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sumador_restador_serial.md
# sumador_restador_serial

Parametrised bit-serial adder/subtractor. It accepts two WIDTH-bit operands and a mode bit through a start/ready handshake. It processes one bit per clock, LSB first, through a single registered full-adder/full-subtractor cell, then presents the result, carry/borrow and signed overflow with a one-cycle done pulse. It is the multi-bit, clocked successor of the single-bit combinational subtractor cell: one cell is reused WIDTH times instead of instantiated WIDTH times.

## Interface
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only on a rising edge where start=1 and ready=1
- op  in  1  0 = add (a+b), 1 = subtract (a-b); sampled at accept
- a  in  WIDTH  minuend/addend; sampled at accept
- b  in  WIDTH  subtrahend/addend; sampled at accept
- ready  out  1  1 when idle and able to accept start
- done  out  1  one-cycle pulse; r/cout/ovf are valid from this cycle onward
- r  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  add: carry out of MSB; subtract: borrow out of MSB (1 iff a < b unsigned)
- ovf  out  1  two's-complement signed overflow of the completed operation

## Operation
- FSM states:
  - IDLE: ready=1.
  - RUN: ready=0; counter i = 0..WIDTH-1.
- IDLE -> RUN on an accepted start:
  - a, b and op are captured into shift registers.
  - The carry/borrow flop is cleared to 0 and i is cleared to 0.
- RUN, each edge:
  - The bit cell processes bit i of the captured operands, with c the carry/borrow flop.
  - Add: s = a^b^c; c' = (a&b)|(a&c)|(b&c).
  - Subtract: s = a^b^c; c' = (~a&b)|(~a&c)|(b&c).
  - s is shifted into the result shift register from the MSB side.
  - c' is stored into the carry/borrow flop, and i increments.
- RUN -> IDLE on the edge that processes i = WIDTH-1. On that same edge:
  - r is loaded with the completed result and cout with the final c'.
  - ovf is loaded with (carry/borrow into MSB) XOR (carry/borrow out of MSB), for both modes.
  - done is set to 1 for exactly one cycle.
- r, cout and ovf are registered. They hold their value until the next completion and are not cleared by start.
- No carry-in port: the carry/borrow flop always starts at 0.
- start while ready=0 is ignored; it is neither queued nor counted.
- Changes on a, b or op after the accept edge have no effect on the running operation.
- Internal counter width is $clog2(WIDTH).

## Timing
- Reset (rst_n=0, asynchronous, takes effect immediately without waiting for a clock edge):
  - FSM goes to IDLE; ready=1, done=0, r=0, cout=0, ovf=0.
  - Shift registers, counter and carry/borrow flop are cleared.
- Reset mid-operation aborts the operation: no done pulse, and outputs go to reset values.
- Latency, with start accepted at edge E0:
  - Bits 0..WIDTH-1 are processed at edges E1..EWIDTH.
  - done=1 and new r/cout/ovf are visible in the cycle after EWIDTH.
- ready is 0 in the cycles after E0..EWIDTH-1 and returns to 1 in the same cycle that done=1.
- A start held high during the done cycle is accepted at edge EWIDTH+1. This is back-to-back operation: one operation per WIDTH+1 cycles.
- done is never high for two consecutive cycles.

## Test plan
- Reset values: assert rst_n=0 between edges -> immediately ready=1, done=0, r=0x00, cout=0, ovf=0.
- Signed add overflow (WIDTH=8): start, op=0, a=0x7F, b=0x01.
  - Exactly 8 edges after the accept edge: done=1, r=0x80, cout=0, ovf=1.
  - done is low on the following cycle.
- Unsigned add wrap (WIDTH=8): op=0, a=0xFF, b=0x01 -> r=0x00, cout=1, ovf=0.
- Subtraction (WIDTH=8):
  - op=1, a=0x05, b=0x07 -> r=0xFE, cout=1, ovf=0.
  - Then op=1, a=0x80, b=0x01 -> r=0x7F, cout=0, ovf=1.
- Handshake (WIDTH=8):
  - Accept op=0, a=0x10, b=0x20.
  - Pulse start with a=0xAA, b=0x55 mid-run and change a/b/op every cycle -> result r=0x30, with exactly one done pulse.
  - Hold start high with op=1, a=0x30, b=0x10 during the done cycle -> accepted at that edge; second done 9 cycles after the first, with r=0x20.
- Reset mid-operation (WIDTH=8):
  - Drop rst_n after 3 bits of op=0, a=0x0F, b=0x01 -> outputs zero at once, ready=1, no done pulse ever.
  - Then run a=0x0F, b=0x01 -> r=0x10, cout=0, ovf=0.
